// File: rtl/mlp_sample_sequencer.sv
// mlp_sample_sequencer
// Streams NUM_A feature beats into a parallel vector for a combinational MLP, holds the vector
// stable for SETTLE cycles, captures the MLP class output, compares it with the sample label
// and presents the result through a valid/ready handshake. Keeps saturating counts of results
// and mismatches.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   feature beat handshake; s_data is the beat, s_label rides on the last beat
//   inp               feature vector to the MLP, feature i at [(i+1)*WIDTH_A-1 : i*WIDTH_A]
//   mlp_out           class produced by the MLP from inp
//   r_valid/r_ready   result handshake; r_class is the captured class, r_match = label agreed
//   smp_cnt, err_cnt  saturating result / mismatch counters
//   clr               synchronous clear of both counters (wins over a same-edge increment)
module mlp_sample_sequencer #(
  parameter int NUM_A    = 21,
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 2,
  parameter int SETTLE   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH_A-1:0]         s_data,
  input  logic [OUTWIDTH-1:0]        s_label,
  output logic [NUM_A*WIDTH_A-1:0]   inp,
  input  logic [OUTWIDTH-1:0]        mlp_out,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [OUTWIDTH-1:0]        r_class,
  output logic                       r_match,
  output logic [CNT_W-1:0]           smp_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  input  logic                       clr
);

  localparam int IdxW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam int SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(NUM_A - 1);
  localparam logic [SetW-1:0]  SetLast = SetW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StLoad, StSettle, StResult} state_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [SetW-1:0]            set_q, set_d;
  logic [NUM_A*WIDTH_A-1:0]   inp_q, inp_d;
  logic [OUTWIDTH-1:0]        label_q, label_d;
  logic [OUTWIDTH-1:0]        class_q, class_d;
  logic                       match_q, match_d;
  logic                       r_valid_q, r_valid_d;
  logic                       s_ready_q, s_ready_d;
  logic [CNT_W-1:0]           smp_q, smp_d;
  logic [CNT_W-1:0]           err_q, err_d;
  logic                       s_fire;
  logic                       capture;
  logic                       mismatch;

  assign s_fire   = s_valid & s_ready_q;
  // The capture edge is the SETTLE-th edge after the last beat: settle counter started at 0.
  assign capture  = (state_q == StSettle) && (set_q == SetLast);
  assign mismatch = (mlp_out != label_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    set_d     = set_q;
    inp_d     = inp_q;
    label_d   = label_q;
    class_d   = class_q;
    match_d   = match_q;
    r_valid_d = r_valid_q;
    s_ready_d = s_ready_q;

    unique case (state_q)
      StLoad: begin
        if (s_fire) begin
          for (int i = 0; i < NUM_A; i++) begin
            if (idx_q == IdxW'(i)) inp_d[i*WIDTH_A +: WIDTH_A] = s_data;
          end
          if (idx_q == IdxLast) begin
            idx_d     = '0;
            label_d   = s_label;
            set_d     = '0;
            s_ready_d = 1'b0;
            state_d   = StSettle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StSettle: begin
        if (capture) begin
          class_d   = mlp_out;
          match_d   = ~mismatch;
          r_valid_d = 1'b1;
          state_d   = StResult;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      StResult: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = StLoad;
        end
      end
      default: begin
        r_valid_d = 1'b0;
        s_ready_d = 1'b1;
        state_d   = StLoad;
      end
    endcase
  end

  always_comb begin
    smp_d = smp_q;
    err_d = err_q;
    if (clr) begin
      smp_d = '0;
      err_d = '0;
    end else if (capture) begin
      if (smp_q != CntMax) smp_d = smp_q + 1'b1;
      if (mismatch && (err_q != CntMax)) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StLoad;
      idx_q     <= '0;
      set_q     <= '0;
      inp_q     <= '0;
      label_q   <= '0;
      class_q   <= '0;
      match_q   <= 1'b0;
      r_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
      smp_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      set_q     <= set_d;
      inp_q     <= inp_d;
      label_q   <= label_d;
      class_q   <= class_d;
      match_q   <= match_d;
      r_valid_q <= r_valid_d;
      s_ready_q <= s_ready_d;
      smp_q     <= smp_d;
      err_q     <= err_d;
    end
  end

  assign s_ready = s_ready_q;
  assign r_valid = r_valid_q;
  assign inp     = inp_q;
  assign r_class = class_q;
  assign r_match = match_q;
  assign smp_cnt = smp_q;
  assign err_cnt = err_q;

endmodule
